// File: rtl/sap1_controlador_sequenciador.sv
// -----------------------------------------------------------------------------
// sap1_controlador_sequenciador
//
// Purpose:
//   Controller/sequencer for the SAP-1 computer. A six-step one-hot ring
//   counter (T1..T6) walks through each instruction. A sticky halt flag stops
//   the machine after an HLT instruction. Every control word bit is a
//   combinational decode of the ring state, the opcode and the halt flag.
//
// Ports:
//   clock   in   1  system clock, all state updates on the rising edge
//   clear   in   1  synchronous active-high reset of ring (to T1) and halt
//   run     in   1  1 = ring advances each clock, 0 = state frozen
//   opcode  in   4  upper nibble of the instruction register (valid T4..T6)
//   t_state out  6  one-hot ring count, bit0 = T1 .. bit5 = T6
//   cp      out  1  program counter increment
//   ep      out  1  program counter drives bus
//   lm      out  1  memory address register load
//   ce      out  1  RAM drives bus
//   li      out  1  instruction register load
//   ei      out  1  instruction register address nibble drives bus
//   la      out  1  accumulator load
//   ea      out  1  accumulator drives bus
//   lb      out  1  B register load
//   su      out  1  ALU subtract select
//   eu      out  1  ALU drives bus
//   lo      out  1  output register load
//   halt    out  1  sticky halt flag, cleared only by clear
//
// Notes:
//   The ring counter is the state machine; t_state exposes it directly so the
//   current step is always observable. Only this block's own state is reset
//   by clear; the datapath registers take clear on their own.
// -----------------------------------------------------------------------------
module sap1_controlador_sequenciador (
  input  logic       clock,
  input  logic       clear,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       lb,
  output logic       su,
  output logic       eu,
  output logic       lo,
  output logic       halt
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  t_state_e r_ring;
  logic     r_halt;
  t_state_e w_ring_next;
  logic     w_halt_next;

  // State register; clear wins over run and halt.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_ring <= T1;
      r_halt <= 1'b0;
    end else begin
      r_ring <= w_ring_next;
      r_halt <= w_halt_next;
    end
  end

  // Next-state: hold unless running and not halted. HLT at T4 parks the ring
  // on T4 and raises halt on the same edge.
  always_comb begin
    w_ring_next = r_ring;
    w_halt_next = r_halt;
    if (run && !r_halt) begin
      if (r_ring == T4 && opcode == OP_HLT) begin
        w_halt_next = 1'b1;
      end else begin
        case (r_ring)
          T1:      w_ring_next = T2;
          T2:      w_ring_next = T3;
          T3:      w_ring_next = T4;
          T4:      w_ring_next = T5;
          T5:      w_ring_next = T6;
          T6:      w_ring_next = T1;
          // A corrupted (non one-hot) ring recovers to the start of fetch.
          default: w_ring_next = T1;
        endcase
      end
    end
  end

  // Control word decode. Everything is forced low during clear and while
  // halted. Fetch (T1..T3) ignores the opcode. Only one of ep/ce/ei/ea/eu is
  // ever raised per step, so the bus has a single driver.
  always_comb begin
    cp = 1'b0;
    ep = 1'b0;
    lm = 1'b0;
    ce = 1'b0;
    li = 1'b0;
    ei = 1'b0;
    la = 1'b0;
    ea = 1'b0;
    lb = 1'b0;
    su = 1'b0;
    eu = 1'b0;
    lo = 1'b0;
    if (!clear && !r_halt) begin
      case (r_ring)
        T1: begin
          ep = 1'b1;
          lm = 1'b1;
        end
        T2: begin
          cp = 1'b1;
        end
        T3: begin
          ce = 1'b1;
          li = 1'b1;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ei = 1'b1;
              lm = 1'b1;
            end
            OP_OUT: begin
              ea = 1'b1;
              lo = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              ce = 1'b1;
              la = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ce = 1'b1;
              lb = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD: begin
              eu = 1'b1;
              la = 1'b1;
            end
            OP_SUB: begin
              eu = 1'b1;
              la = 1'b1;
              su = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign t_state = r_ring;
  assign halt    = r_halt;

endmodule
